// File: rtl/ddr3_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_bridge_pkg
// Shared definitions for the DDR3 FIFO bridge: MIG command encodings, the
// bridge state enum, the 128-bit line type and a helper that aligns a byte
// address down to the start of its cache line.
// ---------------------------------------------------------------------------
package ddr3_bridge_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_CALIB,
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    typedef logic [127:0] line_t;

    // Clears the byte-in-line offset so every address names a 16-byte line.
    function automatic logic [31:0] line_address(input logic [31:0] byte_address);
        return {byte_address[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/ddr3_bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_bridge_sync_fifo
// Small single-clock FIFO with registered pointers, used by the bridge for
// the outstanding-read address queue and the read response buffer.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   push, push_data   write one entry (ignored when full unless popping)
//   pop               remove the head entry (ignored when empty)
//   head              current head entry (show-ahead)
//   empty, full       occupancy flags
//   count             number of stored entries
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module ddr3_bridge_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still legal when the head leaves that cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers carry one wrap bit so full and empty can be told apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

endmodule

// File: rtl/ddr3_fifo_bridge.sv
// ---------------------------------------------------------------------------
// ddr3_fifo_bridge
// Drains the eviction (write) FIFO and the refill (read-in) FIFO, arbitrates
// between them and issues single-beat 128-bit line commands on a MIG-style
// user interface. Read data is paired with its line address and pushed into
// the read-out FIFO in issue order.
// Ports:
//   clk, rst, init_calib_complete       clock, sync reset, MIG ready
//   wfifo_*                             eviction FIFO (FWFT) head and pop
//   rififo_*                            refill request FIFO (FWFT) head and pop
//   rofifo_*                            refill response FIFO push side
//   app_* / app_wdf_* / app_rd_*        MIG user interface
//   protocol_error                      sticky: read data nobody asked for
// ---------------------------------------------------------------------------
module ddr3_fifo_bridge
    import ddr3_bridge_pkg::*;
#(
    parameter int APP_ADDR_W      = 28,
    parameter int ADDR_SHIFT      = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WR_BURST_MAX    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    input  logic                  wfifo_empty,
    input  logic [31:0]           wfifo_address,
    input  logic [127:0]          wfifo_data,
    output logic                  wfifo_read,
    input  logic                  rififo_empty,
    input  logic [31:0]           rififo_address,
    output logic                  rififo_read,
    input  logic                  rofifo_full,
    output logic                  rofifo_write,
    output logic [127:0]          rofifo_data,
    output logic [31:0]           rofifo_address,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [127:0]          app_wdf_data,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [127:0]          app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  protocol_error
);

    localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BURST_W = $clog2(WR_BURST_MAX + 1);

    state_t               state;
    state_t               state_next;
    logic                 cmd_done;
    logic                 data_done;
    logic [BURST_W-1:0]   burst_count;
    logic                 burst_sat;

    logic [31:0]          aq_head;
    logic                 aq_empty;
    logic                 aq_full;
    logic [CNT_W-1:0]     aq_count;
    line_t                rb_head;
    logic                 rb_empty;
    logic                 rb_full;
    logic [CNT_W-1:0]     rb_count;

    logic                 credits_avail;
    logic                 request_pending;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 hazard;
    logic                 pick_write;
    logic                 pick_read;
    logic                 write_issue;
    logic                 read_issue;
    logic                 write_done;
    logic                 read_accept;
    logic [31:0]          wr_shifted;
    logic [31:0]          rd_shifted;
    logic                 unused_bits;

    // Address queue entries cover reads in flight and buffered responses, so
    // its occupancy alone is the number of credits in use.
    assign credits_avail   = aq_count < CNT_W'(MAX_OUTSTANDING);
    assign request_pending = aq_count > rb_count;
    assign burst_sat       = burst_count == BURST_W'(WR_BURST_MAX);

    assign rd_ok  = !rififo_empty && credits_avail;
    assign wr_ok  = !wfifo_empty;
    assign hazard = !wfifo_empty && !rififo_empty && (wfifo_address[31:4] == rififo_address[31:4]);

    assign wr_shifted = line_address(wfifo_address) >> ADDR_SHIFT;
    assign rd_shifted = line_address(rififo_address) >> ADDR_SHIFT;

    assign write_done  = (state == ST_WRITE) && (cmd_done || app_rdy) && (data_done || app_wdf_rdy);
    assign read_accept = (state == ST_READ) && app_rdy;
    assign write_issue = (state == ST_IDLE) && init_calib_complete && pick_write;
    assign read_issue  = (state == ST_IDLE) && init_calib_complete && pick_read;

    // Arbitration: a same-line eviction always goes first so a refill can
    // never fetch stale data; otherwise writes win until the burst limit.
    always_comb begin
        pick_write = 1'b0;
        pick_read  = 1'b0;
        if (hazard) begin
            pick_write = 1'b1;
        end else if (wr_ok && rd_ok) begin
            if (burst_sat) pick_read  = 1'b1;
            else           pick_write = 1'b1;
        end else if (wr_ok) begin
            pick_write = 1'b1;
        end else if (rd_ok) begin
            pick_read = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_CALIB;
        else     state <= state_next;
    end

    // Next-state logic; a dropped calibration lets the current command finish.
    always_comb begin
        state_next = state;
        case (state)
            ST_CALIB: if (init_calib_complete) state_next = ST_IDLE;
            ST_IDLE: begin
                if (!init_calib_complete) state_next = ST_CALIB;
                else if (pick_write)      state_next = ST_WRITE;
                else if (pick_read)       state_next = ST_READ;
            end
            ST_WRITE: if (write_done)  state_next = init_calib_complete ? ST_IDLE : ST_CALIB;
            ST_READ:  if (read_accept) state_next = init_calib_complete ? ST_IDLE : ST_CALIB;
            default:  state_next = ST_CALIB;
        endcase
    end

    // Command and write-data handshakes complete independently in any order.
    always_ff @(posedge clk) begin
        if (rst || state != ST_WRITE || write_done) begin
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (app_rdy)     cmd_done  <= 1'b1;
            if (app_wdf_rdy) data_done <= 1'b1;
        end
    end

    // Counts writes that jumped ahead of a waiting read; any read resets it.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_count <= '0;
        end else if (read_issue) begin
            burst_count <= '0;
        end else if (write_issue && !rififo_empty && !burst_sat) begin
            burst_count <= burst_count + BURST_W'(1);
        end
    end

    // Read data with no unanswered request is dropped and flagged for good.
    always_ff @(posedge clk) begin
        if (rst) begin
            protocol_error <= 1'b0;
        end else if (app_rd_data_valid && !request_pending) begin
            protocol_error <= 1'b1;
        end
    end

    // Output decode from the current state.
    always_comb begin
        app_en       = 1'b0;
        app_cmd      = CMD_WRITE;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        wfifo_read   = 1'b0;
        rififo_read  = 1'b0;
        case (state)
            ST_WRITE: begin
                app_en       = !cmd_done;
                app_addr     = wr_shifted[APP_ADDR_W-1:0];
                app_wdf_data = wfifo_data;
                app_wdf_wren = !data_done;
                app_wdf_end  = !data_done;
                wfifo_read   = write_done;
            end
            ST_READ: begin
                app_en      = 1'b1;
                app_cmd     = CMD_READ;
                app_addr    = rd_shifted[APP_ADDR_W-1:0];
                rififo_read = app_rdy;
            end
            default: ;
        endcase
    end

    // Response path: both queues advance together on each read-out push.
    assign rofifo_write   = !rb_empty && !rofifo_full;
    assign rofifo_data    = rb_empty ? '0 : rb_head;
    assign rofifo_address = rb_empty ? '0 : aq_head;

    ddr3_bridge_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_addr_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (read_accept),
        .push_data (line_address(rififo_address)),
        .pop       (rofifo_write),
        .head      (aq_head),
        .empty     (aq_empty),
        .full      (aq_full),
        .count     (aq_count)
    );

    ddr3_bridge_sync_fifo #(
        .WIDTH (128),
        .DEPTH (MAX_OUTSTANDING)
    ) u_resp_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (app_rd_data_valid && request_pending),
        .push_data (app_rd_data),
        .pop       (rofifo_write),
        .head      (rb_head),
        .empty     (rb_empty),
        .full      (rb_full),
        .count     (rb_count)
    );

    assign unused_bits = ^{wr_shifted, rd_shifted, aq_empty, aq_full, rb_full};

endmodule

// File: tb/tb_ddr3_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_ddr3_fifo_bridge
// Directed bench for ddr3_fifo_bridge. Behavioural FWFT FIFOs and a MIG model
// with fixed read latency surround the DUT; issued commands and read-out
// pushes are logged and compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ddr3_fifo_bridge;
    import ddr3_bridge_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic         wfifo_empty;
    logic [31:0]  wfifo_address;
    logic [127:0] wfifo_data;
    logic         wfifo_read;
    logic         rififo_empty;
    logic [31:0]  rififo_address;
    logic         rififo_read;
    logic         rofifo_full;
    logic         rofifo_write;
    logic [127:0] rofifo_data;
    logic [31:0]  rofifo_address;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         protocol_error;

    // Model state: FIFO contents, MIG pending reads, and observation logs.
    logic [31:0]  wq_addr[$];
    logic [127:0] wq_data[$];
    logic [31:0]  rq_addr[$];
    logic [27:0]  mig_addr[$];
    int           mig_due[$];
    logic [31:0]  cmd_log[$];
    logic [31:0]  ro_addr_log[$];
    logic [127:0] ro_data_log[$];

    logic cfg_rst, cfg_calib, cfg_app_rdy, cfg_wdf_rdy, cfg_full, cfg_spur;
    logic pend_wpop, pend_rpop;
    logic any_en;
    int   cycle;
    int   wpop_count;
    int   ro_while_full;
    int   checks;
    int   errors;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    ddr3_fifo_bridge dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .wfifo_empty         (wfifo_empty),
        .wfifo_address       (wfifo_address),
        .wfifo_data          (wfifo_data),
        .wfifo_read          (wfifo_read),
        .rififo_empty        (rififo_empty),
        .rififo_address      (rififo_address),
        .rififo_read         (rififo_read),
        .rofifo_full         (rofifo_full),
        .rofifo_write        (rofifo_write),
        .rofifo_data         (rofifo_data),
        .rofifo_address      (rofifo_address),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .protocol_error      (protocol_error)
    );

    // Advances n cycles: drives inputs at the falling edge, then samples the
    // DUT outputs 1 ns later, well before the next rising edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (pend_wpop && wq_addr.size() > 0) begin
                void'(wq_addr.pop_front());
                void'(wq_data.pop_front());
            end
            if (pend_rpop && rq_addr.size() > 0) void'(rq_addr.pop_front());
            rst                 = cfg_rst;
            init_calib_complete = cfg_calib;
            app_rdy             = cfg_app_rdy;
            app_wdf_rdy         = cfg_wdf_rdy;
            rofifo_full         = cfg_full;
            wfifo_empty         = (wq_addr.size() == 0);
            wfifo_address       = wfifo_empty ? 32'h0 : wq_addr[0];
            wfifo_data          = wfifo_empty ? 128'h0 : wq_data[0];
            rififo_empty        = (rq_addr.size() == 0);
            rififo_address      = rififo_empty ? 32'h0 : rq_addr[0];
            app_rd_data_valid   = 1'b0;
            app_rd_data         = '0;
            if (cfg_spur) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = {4{32'hDEAD_BEEF}};
                cfg_spur          = 1'b0;
            end else if (mig_due.size() > 0 && mig_due[0] <= cycle) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = {4{4'h0, mig_addr[0]}};
                void'(mig_addr.pop_front());
                void'(mig_due.pop_front());
            end
            #1;
            pend_wpop = wfifo_read;
            pend_rpop = rififo_read;
            if (wfifo_read) wpop_count++;
            if (app_en && app_rdy) begin
                cmd_log.push_back({app_cmd, 1'b0, app_addr});
                if (app_cmd == CMD_READ) begin
                    mig_addr.push_back(app_addr);
                    mig_due.push_back(cycle + 3);
                end
            end
            if (rofifo_write) begin
                if (rofifo_full) ro_while_full++;
                ro_addr_log.push_back(rofifo_address);
                ro_data_log.push_back(rofifo_data);
            end
            cycle++;
        end
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Out-of-range log reads return a marker that no expected value uses.
    function automatic logic [31:0] cmdAt(input int i);
        return (i < cmd_log.size()) ? cmd_log[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] roAddrAt(input int i);
        return (i < ro_addr_log.size()) ? ro_addr_log[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [127:0] roDataAt(input int i);
        return (i < ro_data_log.size()) ? ro_data_log[i] : {128{1'b1}};
    endfunction

    task automatic clearLogs();
        cmd_log.delete();
        ro_addr_log.delete();
        ro_data_log.delete();
        wpop_count    = 0;
        ro_while_full = 0;
    endtask

    // Directed sequence.
    initial begin
        checks = 0; errors = 0; cycle = 0;
        wpop_count = 0; ro_while_full = 0;
        pend_wpop = 1'b0; pend_rpop = 1'b0;
        cfg_rst = 1'b1; cfg_calib = 1'b0; cfg_app_rdy = 1'b1;
        cfg_wdf_rdy = 1'b1; cfg_full = 1'b0; cfg_spur = 1'b0;
        rst = 1'b1; init_calib_complete = 1'b0; wfifo_empty = 1'b1;
        wfifo_address = '0; wfifo_data = '0; rififo_empty = 1'b1;
        rififo_address = '0; rofifo_full = 1'b0; app_rdy = 1'b1;
        app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;

        $display("[TB] reset");
        applyStimulus(3);
        checkOutput("rst_app_en", app_en, 0);
        checkOutput("rst_wdf_wren", app_wdf_wren, 0);
        checkOutput("rst_wfifo_read", wfifo_read, 0);
        checkOutput("rst_rififo_read", rififo_read, 0);
        checkOutput("rst_rofifo_write", rofifo_write, 0);
        checkOutput("rst_protocol_error", protocol_error, 0);
        cfg_rst = 1'b0;

        $display("[TB] calibration gating and write handshake skew");
        wq_addr.push_back(32'h0000_0100);
        wq_data.push_back(128'hC0DE_0001_0000_0000_0000_0000_0000_0100);
        rq_addr.push_back(32'h0000_0500);
        cfg_wdf_rdy = 1'b0;
        any_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            any_en = any_en | app_en;
        end
        checkOutput("calib_gate_app_en", any_en, 0);
        cfg_calib = 1'b1;
        applyStimulus(2);
        applyStimulus(1);
        checkOutput("wr_c1_app_en", app_en, 1);
        checkOutput("wr_c1_app_cmd", app_cmd, 3'b000);
        checkOutput("wr_c1_app_addr", app_addr, 28'h80);
        checkOutput("wr_c1_wren", app_wdf_wren, 1);
        checkOutput("wr_c1_wdf_end", app_wdf_end, 1);
        checkOutput("wr_c1_wdf_data", app_wdf_data, 128'hC0DE_0001_0000_0000_0000_0000_0000_0100);
        applyStimulus(1);
        checkOutput("wr_c2_app_en", app_en, 0);
        checkOutput("wr_c2_wren", app_wdf_wren, 1);
        applyStimulus(1);
        checkOutput("wr_c3_wren", app_wdf_wren, 1);
        checkOutput("wr_c3_wfifo_read", wfifo_read, 0);
        cfg_wdf_rdy = 1'b1;
        applyStimulus(1);
        checkOutput("wr_c4_wren", app_wdf_wren, 1);
        checkOutput("wr_c4_wfifo_read", wfifo_read, 1);
        applyStimulus(1);
        checkOutput("wr_c5_wren", app_wdf_wren, 0);
        checkOutput("wr_c5_wfifo_read", wfifo_read, 0);
        applyStimulus(12);
        checkOutput("wr_pop_count", wpop_count, 1);
        checkOutput("t1_cmd0", cmdAt(0), 32'h0000_0080);
        checkOutput("t1_cmd1", cmdAt(1), 32'h2000_0280);
        checkOutput("t1_ro_addr", roAddrAt(0), 32'h0000_0500);
        checkOutput("t1_ro_data", roDataAt(0), {4{32'h0000_0280}});

        $display("[TB] hazard ordering with saturated burst counter");
        clearLogs();
        for (int i = 0; i < 4; i++) begin
            wq_addr.push_back(32'h3000 + 32'(16 * i));
            wq_data.push_back({96'h0, 32'h3000 + 32'(16 * i)});
        end
        wq_addr.push_back(32'h2000);
        wq_data.push_back({96'h0, 32'h2000});
        rq_addr.push_back(32'h2004);
        applyStimulus(40);
        checkOutput("hz_cmd3", cmdAt(3), 32'h0000_1818);
        checkOutput("hz_cmd4_write", cmdAt(4), 32'h0000_1000);
        checkOutput("hz_cmd5_read", cmdAt(5), 32'h2000_1000);
        checkOutput("hz_cmd_count", cmd_log.size(), 6);
        checkOutput("hz_ro_addr", roAddrAt(0), 32'h0000_2000);

        $display("[TB] write burst limit");
        clearLogs();
        for (int i = 0; i < 8; i++) begin
            wq_addr.push_back(32'h4000 + 32'(16 * i));
            wq_data.push_back({96'h0, 32'h4000 + 32'(16 * i)});
        end
        rq_addr.push_back(32'h0000_0040);
        applyStimulus(50);
        checkOutput("sv_cmd0", cmdAt(0), 32'h0000_2000);
        checkOutput("sv_cmd3", cmdAt(3), 32'h0000_2018);
        checkOutput("sv_cmd4_read", cmdAt(4), 32'h2000_0020);
        checkOutput("sv_cmd5", cmdAt(5), 32'h0000_2020);
        checkOutput("sv_cmd8", cmdAt(8), 32'h0000_2038);
        checkOutput("sv_cmd_count", cmd_log.size(), 9);
        checkOutput("sv_ro_addr", roAddrAt(0), 32'h0000_0040);
        checkOutput("no_protocol_error", protocol_error, 0);

        $display("[TB] read credit limit");
        clearLogs();
        cfg_full = 1'b1;
        for (int i = 0; i < 6; i++) rq_addr.push_back(32'h6000 + 32'(16 * i));
        applyStimulus(40);
        checkOutput("cr_reads_while_full", cmd_log.size(), 4);
        checkOutput("cr_ro_while_full", ro_addr_log.size(), 0);
        cfg_full = 1'b0;
        applyStimulus(40);
        checkOutput("cr_reads_total", cmd_log.size(), 6);
        checkOutput("cr_cmd4", cmdAt(4), 32'h2000_3020);
        checkOutput("cr_ro_count", ro_addr_log.size(), 6);
        checkOutput("cr_ro_addr0", roAddrAt(0), 32'h0000_6000);
        checkOutput("cr_ro_addr3", roAddrAt(3), 32'h0000_6030);
        checkOutput("cr_ro_addr5", roAddrAt(5), 32'h0000_6050);
        checkOutput("cr_ro_data5", roDataAt(5), {4{32'h0000_3028}});
        checkOutput("cr_write_when_full", ro_while_full, 0);

        $display("[TB] spurious read data");
        clearLogs();
        cfg_spur = 1'b1;
        applyStimulus(1);
        checkOutput("sp_rofifo_write_now", rofifo_write, 0);
        applyStimulus(1);
        checkOutput("sp_protocol_error", protocol_error, 1);
        applyStimulus(10);
        checkOutput("sp_protocol_sticky", protocol_error, 1);
        checkOutput("sp_no_ro_push", ro_addr_log.size(), 0);
        cfg_rst = 1'b1;
        applyStimulus(1);
        checkOutput("sp_before_rst_edge", protocol_error, 1);
        applyStimulus(1);
        checkOutput("sp_cleared_by_rst", protocol_error, 0);
        cfg_rst = 1'b0;
        applyStimulus(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
